// File: rtl/imgbusarb_if.sv
// imgbusarb_if: one pipelined Wishbone link.
// The "master" modport is the side that issues requests, and the "slave"
// modport is the side that answers them. The arbiter acts as a slave to
// each fetcher and as a master to the shared memory bus.
interface imgbusarb_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] sel;
  logic            stall;
  logic            ack;
  logic            err;
  logic [DW-1:0]   rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, err, rdata
  );
endinterface

// File: rtl/imgbusarb.sv
// imgbusarb: two-master pipelined Wishbone arbiter.
// Two image-fetch masters share one memory bus. Ownership lasts for a whole
// bus cycle, from the rise of CYC until the owner drops it. Contention in
// IDLE is resolved round-robin through last_owner.
// Build option IMGARB_FIXED_PRIORITY_EN: when defined, master A wins every
// contention. This suits the case where A is the display path.
//
// state | meaning
// IDLE  | nobody owns the bus; shared CYC/STB are forced low
// OWN_A | master A owns the bus until it drops CYC
// OWN_B | master B owns the bus until it drops CYC
module imgbusarb #(
  parameter int AW = 24,
  parameter int DW = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  imgbusarb_if.slave  io_a,
  imgbusarb_if.slave  io_b,
  imgbusarb_if.master io_wb,
  output logic [1:0] o_owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_owner;   // 0 = A, 1 = B
  logic            w_last_nxt;
  logic            w_own_a;
  logic            w_own_b;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [DW/8-1:0] w_sel;

  // Grant state and round-robin memory. After reset last_owner is B, so A
  // wins the first contention. Because the reset is asynchronous, the shared
  // CYC drops as soon as reset asserts.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

  // Next-state decode, plus muxing of the request and return paths by owner.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_owner;
    w_own_a     = (r_state == OWN_A);
    w_own_b     = (r_state == OWN_B);

    case (r_state)
      IDLE: begin
        if (io_a.cyc && io_b.cyc) begin
`ifdef IMGARB_FIXED_PRIORITY_EN
          w_state_nxt = OWN_A;
`else
          w_state_nxt = r_last_owner ? OWN_A : OWN_B;
`endif
        end else if (io_a.cyc) begin
          w_state_nxt = OWN_A;
        end else if (io_b.cyc) begin
          w_state_nxt = OWN_B;
        end
      end
      OWN_A: begin
        if (!io_a.cyc) begin
          w_state_nxt = IDLE;
          w_last_nxt  = 1'b0;
        end
      end
      OWN_B: begin
        if (!io_b.cyc) begin
          w_state_nxt = IDLE;
          w_last_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Address, data, select and WE follow B only while B owns the bus.
    // In every other state they come from A.
    w_addr  = w_own_b ? io_b.addr  : io_a.addr;
    w_wdata = w_own_b ? io_b.wdata : io_a.wdata;
    w_sel   = w_own_b ? io_b.sel   : io_a.sel;
  end

  assign io_wb.cyc   = (w_own_a & io_a.cyc) | (w_own_b & io_b.cyc);
  assign io_wb.stb   = (w_own_a & io_a.stb) | (w_own_b & io_b.stb);
  assign io_wb.we    = w_own_b ? io_b.we : io_a.we;
  assign io_wb.addr  = w_addr;
  assign io_wb.wdata = w_wdata;
  assign io_wb.sel   = w_sel;

  // A master that does not own the bus sees a permanent stall and no responses.
  // An ack that arrives while the arbiter is IDLE reaches neither master.
  assign io_a.stall = w_own_a ? io_wb.stall : 1'b1;
  assign io_a.ack   = w_own_a & io_wb.ack;
  assign io_a.err   = w_own_a & io_wb.err;
  assign io_a.rdata = io_wb.rdata;

  assign io_b.stall = w_own_b ? io_wb.stall : 1'b1;
  assign io_b.ack   = w_own_b & io_wb.ack;
  assign io_b.err   = w_own_b & io_wb.err;
  assign io_b.rdata = io_wb.rdata;

  assign o_owner = {w_own_b, w_own_a};

endmodule

// File: tb/tb_imgbusarb.sv
// tb_imgbusarb: directed bench for the two-master Wishbone arbiter.
// The expected values are constants derived by hand from the grant and
// handoff timing. Define IMGARB_FIXED_PRIORITY_EN when building to check the
// fixed-priority contention order.
module tb_imgbusarb;

  logic       i_clk;
  logic       i_reset;
  logic [1:0] o_owner;
  int         n_checks;
  int         n_fail;

  imgbusarb_if #(.AW(24), .DW(32)) a_if ();
  imgbusarb_if #(.AW(24), .DW(32)) b_if ();
  imgbusarb_if #(.AW(24), .DW(32)) wb_if ();

  imgbusarb #(.AW(24), .DW(32)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .io_a    (a_if),
    .io_b    (b_if),
    .io_wb   (wb_if),
    .o_owner (o_owner)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle_inputs();
    a_if.cyc = 1'b0; a_if.stb = 1'b0; a_if.we = 1'b0;
    a_if.addr = '0; a_if.wdata = '0; a_if.sel = '0;
    b_if.cyc = 1'b0; b_if.stb = 1'b0; b_if.we = 1'b0;
    b_if.addr = '0; b_if.wdata = '0; b_if.sel = '0;
    wb_if.stall = 1'b0; wb_if.ack = 1'b0; wb_if.err = 1'b0; wb_if.rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  logic [1:0] exp_rr [4];
  int n_ack_a;
  int n_ack_b;
  int t;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef IMGARB_FIXED_PRIORITY_EN
    exp_rr = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

    // Reset values.
    do_reset();
    #1;
    check_eq("rst_owner",   32'(o_owner), 0);
    check_eq("rst_wb_cyc",  32'(wb_if.cyc), 0);
    check_eq("rst_wb_stb",  32'(wb_if.stb), 0);
    check_eq("rst_a_stall", 32'(a_if.stall), 1);
    check_eq("rst_b_stall", 32'(b_if.stall), 1);
    check_eq("rst_a_ack",   32'(a_if.ack), 0);
    check_eq("rst_b_ack",   32'(b_if.ack), 0);
    check_eq("rst_a_err",   32'(a_if.err), 0);
    check_eq("rst_b_err",   32'(b_if.err), 0);

    // Test 1: single master A runs a 4-beat burst, and each ack comes 2 cycles after its request.
    a_if.cyc = 1'b1; a_if.stb = 1'b1; a_if.addr = 24'h100;
    #1;
    check_eq("t1_pre_stall",  32'(a_if.stall), 1);
    check_eq("t1_pre_wb_cyc", 32'(wb_if.cyc), 0);
    n_ack_a = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      a_if.stb    = (k < 4);
      a_if.addr   = 24'(32'h100 + ((k < 4) ? k : 3));
      wb_if.ack   = (k >= 2);
      wb_if.rdata = 32'hD000 + k;
      #1;
      check_eq("t1_owner",  32'(o_owner), 1);
      check_eq("t1_wb_cyc", 32'(wb_if.cyc), 1);
      check_eq("t1_wb_stb", 32'(wb_if.stb), (k < 4) ? 1 : 0);
      if (k < 4) check_eq("t1_wb_addr", 32'(wb_if.addr), 32'h100 + k);
      check_eq("t1_a_stall", 32'(a_if.stall), 0);
      check_eq("t1_a_ack",  32'(a_if.ack), (k >= 2) ? 1 : 0);
      check_eq("t1_b_ack",  32'(b_if.ack), 0);
      check_eq("t1_a_data", a_if.rdata, 32'hD000 + k);
      check_eq("t1_b_data", b_if.rdata, 32'hD000 + k);
      n_ack_a += int'(a_if.ack);
    end
    check_eq("t1_ack_count", 32'(n_ack_a), 4);
    step();
    a_if.cyc = 1'b0; a_if.stb = 1'b0; wb_if.ack = 1'b0;
    #1;
    check_eq("t1_drop_wb_cyc", 32'(wb_if.cyc), 0);
    step();
    #1;
    check_eq("t1_idle_owner", 32'(o_owner), 0);

    // Test 2: A and B both request straight after reset, so A wins, and B is granted 2 edges after A releases.
    do_reset();
    a_if.cyc = 1'b1; a_if.stb = 1'b1; a_if.addr = 24'h200;
    b_if.cyc = 1'b1; b_if.stb = 1'b1; b_if.addr = 24'h300;
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      check_eq("t2_owner_a",  32'(o_owner), 1);
      check_eq("t2_b_stall",  32'(b_if.stall), 1);
      check_eq("t2_wb_addr",  32'(wb_if.addr), 32'h200);
    end
    step();
    a_if.cyc = 1'b0; a_if.stb = 1'b0;
    #1;
    check_eq("t2_rel_b_stall", 32'(b_if.stall), 1);
    step();
    #1;
    check_eq("t2_gap_owner",  32'(o_owner), 0);
    check_eq("t2_gap_wb_cyc", 32'(wb_if.cyc), 0);
    check_eq("t2_gap_b_stall", 32'(b_if.stall), 1);
    step();
    #1;
    check_eq("t2_owner_b",  32'(o_owner), 2);
    check_eq("t2_b_addr",   32'(wb_if.addr), 32'h300);
    check_eq("t2_b_stall2", 32'(b_if.stall), 0);
    b_if.cyc = 1'b0; b_if.stb = 1'b0;
    step();

    // Test 3: both masters request continuously, and each owner releases after 8 acks.
    do_reset();
    a_if.cyc = 1'b1; a_if.stb = 1'b1;
    b_if.cyc = 1'b1; b_if.stb = 1'b1;
    wb_if.ack = 1'b1;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      do begin
        step();
        #1;
        t++;
      end while (o_owner == 2'b00 && t < 4);
      check_eq("t3_owner", 32'(o_owner), 32'(exp_rr[g]));
      n_ack_a = 0;
      n_ack_b = 0;
      for (int k = 0; k < 8; k++) begin
        if (k > 0) begin
          step();
          #1;
        end
        n_ack_a += int'(a_if.ack);
        n_ack_b += int'(b_if.ack);
      end
      check_eq("t3_acks_a", 32'(n_ack_a), (exp_rr[g] == 2'b01) ? 8 : 0);
      check_eq("t3_acks_b", 32'(n_ack_b), (exp_rr[g] == 2'b10) ? 8 : 0);
      step();
      wb_if.ack = 1'b0;
      if (o_owner == 2'b01) a_if.cyc = 1'b0;
      else b_if.cyc = 1'b0;
      step();
      a_if.cyc = 1'b1; b_if.cyc = 1'b1;
      wb_if.ack = 1'b1;
    end
    idle_inputs();
    step();
    step();

    // Test 4: the slave signals an error to owner B on B's third request, then A takes over once B drops CYC.
    do_reset();
    b_if.cyc = 1'b1; b_if.stb = 1'b1; b_if.addr = 24'h400;
    step();
    #1;
    check_eq("t4_owner_b", 32'(o_owner), 2);
    step();
    b_if.addr = 24'h401;
    a_if.cyc = 1'b1; a_if.stb = 1'b1;
    step();
    b_if.addr = 24'h402;
    wb_if.err = 1'b1;
    #1;
    check_eq("t4_b_err",   32'(b_if.err), 1);
    check_eq("t4_a_err",   32'(a_if.err), 0);
    check_eq("t4_b_ack",   32'(b_if.ack), 0);
    check_eq("t4_a_stall", 32'(a_if.stall), 1);
    step();
    wb_if.err = 1'b0;
    b_if.cyc = 1'b0; b_if.stb = 1'b0;
    #1;
    check_eq("t4_b_err_gone", 32'(b_if.err), 0);
    step();
    #1;
    check_eq("t4_idle", 32'(o_owner), 0);
    step();
    #1;
    check_eq("t4_owner_a", 32'(o_owner), 1);

    // Test 5: reset is asserted asynchronously while A has 5 requests outstanding.
    do_reset();
    a_if.cyc = 1'b1; a_if.stb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      a_if.addr = 24'(32'h500 + k);
    end
    #1;
    check_eq("t5_pre_wb_cyc", 32'(wb_if.cyc), 1);
    i_reset = 1'b1;
    #1;
    check_eq("t5_rst_wb_cyc",  32'(wb_if.cyc), 0);
    check_eq("t5_rst_wb_stb",  32'(wb_if.stb), 0);
    check_eq("t5_rst_owner",   32'(o_owner), 0);
    check_eq("t5_rst_a_stall", 32'(a_if.stall), 1);
    step();
    i_reset = 1'b0;
    #1;
    check_eq("t5_rel_owner", 32'(o_owner), 0);
    step();
    #1;
    check_eq("t5_regrant_owner",  32'(o_owner), 1);
    check_eq("t5_regrant_wb_cyc", 32'(wb_if.cyc), 1);
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
